// File: rtl/gpio_port.sv
// Pad-side GPIO stage: tri-state pad drive, two-flop synchroniser, per-pin
// debounce, sticky edge flags with write-1-to-clear and a shared interrupt.

module gpio_pin #(
   parameter int DB_CYCLES = 4,
   parameter int CNT_W     = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic pad_i,
   input  logic cr_i,
   input  logic clr_i,
   output logic ir_o,
   output logic flag_o
);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

   logic             s1_q, s2_q;
   logic             stable_q, stable_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             flag_q, flag_d;
   logic             toggle;

   // A toggle is the final mismatching sample of a full debounce window.
   assign toggle = (s2_q != stable_q) && (cnt_q == CNT_LAST);

   always_comb begin
      stable_d = stable_q;
      cnt_d    = cnt_q;
      if (s2_q == stable_q) begin
         cnt_d = '0;
      end else if (toggle) begin
         stable_d = s2_q;
         cnt_d    = '0;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Set beats clear; pins driven as outputs never raise a flag.
   always_comb begin
      flag_d = flag_q;
      if (toggle && !cr_i) flag_d = 1'b1;
      else if (clr_i)      flag_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_q     <= 1'b0;
         s2_q     <= 1'b0;
         stable_q <= 1'b0;
         cnt_q    <= '0;
         flag_q   <= 1'b0;
      end else begin
         s1_q     <= pad_i;
         s2_q     <= s1_q;
         stable_q <= stable_d;
         cnt_q    <= cnt_d;
         flag_q   <= flag_d;
      end
   end

   assign ir_o   = stable_q;
   assign flag_o = flag_q;
endmodule

module gpio_port #(
   parameter int WIDTH     = 32,
   parameter int DB_CYCLES = 4,
   parameter int CNT_W     = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] gpio_cr,
   input  logic [WIDTH-1:0] gpio_or,
   output logic [WIDTH-1:0] gpio_ir,
   inout  wire  [WIDTH-1:0] gpio_pad,
   input  logic [WIDTH-1:0] flag_clr,
   output logic [WIDTH-1:0] edge_flag,
   output logic             irq
);
   for (genvar i = 0; i < WIDTH; i++) begin : g_pin
      // Pads float during reset so nothing is driven before software sets up.
      assign gpio_pad[i] = (gpio_cr[i] && !rst) ? gpio_or[i] : 1'bz;

      gpio_pin #(
         .DB_CYCLES(DB_CYCLES),
         .CNT_W    (CNT_W)
      ) u_pin (
         .clk   (clk),
         .rst   (rst),
         .pad_i (gpio_pad[i]),
         .cr_i  (gpio_cr[i]),
         .clr_i (flag_clr[i]),
         .ir_o  (gpio_ir[i]),
         .flag_o(edge_flag[i])
      );
   end

   assign irq = |edge_flag;
endmodule

// File: tb/tb_gpio_port.sv
// Directed bench for gpio_port: drive, debounce latency, glitch rejection,
// write-1-to-clear priority, output pins and mid-debounce reset.

module tb_gpio_port;
   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst;
   logic [W-1:0] gpio_cr, gpio_or, flag_clr, gpio_ir, edge_flag;
   logic         irq;
   wire  [W-1:0] gpio_pad;
   logic [W-1:0] tb_en, tb_val;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   for (genvar i = 0; i < W; i++) begin : g_drv
      assign gpio_pad[i] = tb_en[i] ? tb_val[i] : 1'bz;
   end

   gpio_port #(.WIDTH(W), .DB_CYCLES(4), .CNT_W(4)) dut (
      .clk      (clk),
      .rst      (rst),
      .gpio_cr  (gpio_cr),
      .gpio_or  (gpio_or),
      .gpio_ir  (gpio_ir),
      .gpio_pad (gpio_pad),
      .flag_clr (flag_clr),
      .edge_flag(edge_flag),
      .irq      (irq)
   );

   task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Advance one clock edge; inputs change and outputs are sampled 1ns later.
   task automatic step(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      rst = 1'b1; gpio_cr = '1; gpio_or = '0; flag_clr = '0;
      tb_en = '1; tb_val = '1;
      step(2);
      // 1: reset releases pads (bench alone drives them high), outputs clear
      check("rst_pad_released", gpio_pad, 32'hFFFF_FFFF);
      check("rst_ir", gpio_ir, 32'h0);
      check("rst_flag", edge_flag, 32'h0);
      check("rst_irq", {31'b0, irq}, 32'h0);

      tb_en = 32'hFFFF_FF00; tb_val = '0;
      rst = 1'b0; gpio_cr = 32'h0000_00FF; gpio_or = 32'h0000_00A5;
      #1;
      check("drive_pad", gpio_pad, 32'h0000_00A5);
      step(5);
      check("drive_ir_edge5", gpio_ir, 32'h0);
      step(1);
      check("drive_ir_edge6", gpio_ir, 32'h0000_00A5);
      check("drive_noflag", edge_flag, 32'h0);

      // 2: switch to inputs at the same level, then raise pad 3
      gpio_cr = '0; tb_en = '1; tb_val = 32'h0000_00A5;
      step(8);
      check("dir_swap_noflag", edge_flag, 32'h0);
      tb_val[3] = 1'b1;
      step(5);
      check("lat_ir_edge5", gpio_ir, 32'h0000_00A5);
      check("lat_irq_edge5", {31'b0, irq}, 32'h0);
      step(1);
      check("lat_ir_edge6", gpio_ir, 32'h0000_00AD);
      check("lat_flag_edge6", edge_flag, 32'h8);
      check("lat_irq_edge6", {31'b0, irq}, 32'h1);
      flag_clr = 32'h8; step(1); flag_clr = '0;
      check("w1c_flag", edge_flag, 32'h0);
      check("w1c_irq", {31'b0, irq}, 32'h0);

      // 3: return pad 3 low, then a 3-sample glitch and a 5-sample pulse
      tb_val[3] = 1'b0; step(8);
      check("fall_flag", edge_flag, 32'h8);
      flag_clr = 32'h8; step(1); flag_clr = '0;
      tb_val[3] = 1'b1; step(3); tb_val[3] = 1'b0;
      step(10);
      check("glitch_ir", gpio_ir, 32'h0000_00A5);
      check("glitch_flag", edge_flag, 32'h0);
      tb_val[3] = 1'b1; step(5); tb_val[3] = 1'b0;
      step(1);
      check("pulse_ir_high", gpio_ir, 32'h0000_00AD);
      step(10);
      check("pulse_ir_low", gpio_ir, 32'h0000_00A5);
      check("pulse_flag", edge_flag, 32'h8);
      flag_clr = 32'h8; step(1); flag_clr = '0;

      // 4: flags 0 and 3, clear bit 0, then clear bit 3 as it toggles again
      tb_val[0] = 1'b0; tb_val[3] = 1'b1;
      step(6);
      check("two_flags", edge_flag, 32'h9);
      check("two_ir", gpio_ir, 32'h0000_00AC);
      tb_val[3] = 1'b0;
      flag_clr = 32'h1; step(1); flag_clr = '0;
      check("clr_bit0", edge_flag, 32'h8);
      check("clr_bit0_irq", {31'b0, irq}, 32'h1);
      step(4);
      flag_clr = 32'h8; step(1); flag_clr = '0;
      check("set_wins", edge_flag, 32'h8);
      check("set_wins_ir", gpio_ir, 32'h0000_00A4);
      flag_clr = 32'h8; step(1); flag_clr = '0;
      check("clr_bit3", edge_flag, 32'h0);

      // 5: pin 5 as output, readback toggles with no flag
      tb_en[5] = 1'b0; gpio_cr[5] = 1'b1; gpio_or[5] = 1'b0;
      step(6);
      check("out_ir_low", gpio_ir, 32'h0000_0084);
      gpio_or[5] = 1'b1;
      #1;
      check("out_pad", {31'b0, gpio_pad[5]}, 32'h1);
      step(5);
      check("out_ir_edge5", gpio_ir, 32'h0000_0084);
      step(1);
      check("out_ir_edge6", gpio_ir, 32'h0000_00A4);
      check("out_noflag", edge_flag, 32'h0);
      tb_val[5] = 1'b1; tb_en[5] = 1'b1; gpio_cr[5] = 1'b0;
      step(3);

      // 6: reset with pin 2 part-way through a debounce
      tb_val[2] = 1'b0;
      step(4);
      rst = 1'b1; tb_val[2] = 1'b1;
      step(1);
      rst = 1'b0;
      check("mid_rst_ir", gpio_ir, 32'h0);
      check("mid_rst_flag", edge_flag, 32'h0);
      check("mid_rst_irq", {31'b0, irq}, 32'h0);
      step(5);
      check("post_rst_edge5", gpio_ir, 32'h0);
      step(1);
      check("post_rst_ir", gpio_ir, 32'h0000_00A4);
      check("post_rst_flag", edge_flag, 32'h0000_00A4);
      check("post_rst_irq", {31'b0, irq}, 32'h1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
